// File: rtl/mult_serial_acc.sv
// Bit-serial multiply-accumulate: M-bit parallel operand times an N-bit LSB-first
// serial operand, product streamed LSB-first and summed into a wrapping accumulator.
module mult_serial_acc #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [M-1:0]     x,
  input  logic             a_bit,
  input  logic             clr_acc,
  output logic             busy,
  output logic             p_bit,
  output logic             p_valid,
  output logic             done,
  output logic [ACC_W-1:0] acc
);
  localparam int L  = M + N;
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t state_q, state_d;

  logic [M-1:0]     x_q;
  logic [M:0]       s_q;
  logic [L-1:0]     prod_q;
  logic [CW-1:0]    cnt_q;
  logic             clr_q;

  logic             accept, step, ak;
  logic [CW-1:0]    k;
  logic [M-1:0]     xs;
  logic [M+1:0]     xe, se, addend, t;
  logic [ACC_W-1:0] pext;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CW'(L - 1)) state_d = LAST;
      LAST:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LAST is the cycle carrying the final product bit; it doubles as the done pulse.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == LAST);
    p_valid = busy;
  end

  // Step 0 runs on the accepting edge, so it uses the live x and a zero partial sum.
  always_comb begin
    accept = start && (state_q == IDLE || state_q == LAST);
    step   = accept || (state_q == RUN);
    k      = accept ? '0 : cnt_q;
    xs     = accept ? x : x_q;
    xe     = (SIGNED != 0) ? {{2{xs[M-1]}}, xs} : {2'b00, xs};
    se     = accept ? '0 : ((SIGNED != 0) ? {s_q[M], s_q} : {1'b0, s_q});
    ak     = a_bit && (k < CW'(N));
    addend = '0;
    if (ak) addend = ((SIGNED != 0) && (k == CW'(N - 1))) ? -xe : xe;
    t      = se + addend;
    pext   = (SIGNED != 0) ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
  end

  // T is one bit wider than S so the shift below is arithmetic or logical for free.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q    <= '0;
      s_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      clr_q  <= 1'b0;
      p_bit  <= 1'b0;
      acc    <= '0;
    end else begin
      if (step) begin
        p_bit  <= t[0];
        s_q    <= t[M+1:1];
        prod_q <= {t[0], prod_q[L-1:1]};
        cnt_q  <= k + 1'b1;
      end else begin
        p_bit  <= 1'b0;
        cnt_q  <= '0;
      end
      if (accept) begin
        x_q   <= x;
        clr_q <= clr_acc;
      end
      if (state_q == LAST) acc <= (clr_q ? '0 : acc) + pext;
    end
endmodule

// File: tb/tb_mult_serial_acc.sv
// Bench for mult_serial_acc: unsigned and signed instances share stimulus and are
// checked against an arithmetic product/accumulator model.
module tb_mult_serial_acc;
  localparam int M = 8, N = 8, W = 20, L = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, a_bit = 1'b0, clr_acc = 1'b0;
  logic [M-1:0] x = '0;
  logic busy0, pb0, pv0, done0, busy1, pb1, pv1, done1;
  logic [W-1:0] acc0, acc1;

  int errs = 0, checks = 0;
  logic [W-1:0] macc0 = '0, macc1 = '0;
  logic [7:0] qx[$], qa[$];
  bit qc[$];

  mult_serial_acc #(.M(M), .N(N), .ACC_W(W), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .x(x), .a_bit(a_bit), .clr_acc(clr_acc),
    .busy(busy0), .p_bit(pb0), .p_valid(pv0), .done(done0), .acc(acc0));
  mult_serial_acc #(.M(M), .N(N), .ACC_W(W), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .x(x), .a_bit(a_bit), .clr_acc(clr_acc),
    .busy(busy1), .p_bit(pb1), .p_valid(pv1), .done(done1), .acc(acc1));

  always #5 clk = ~clk;

  function automatic logic [15:0] prod(input logic [7:0] xv, input logic [7:0] av, input bit sg);
    int sx, sa, p;
    if (sg) begin sx = int'($signed(xv)); sa = int'($signed(av)); end
    else    begin sx = int'(xv);          sa = int'(av);          end
    p = sx * sa;
    return p[15:0];
  endfunction

  function automatic logic [W-1:0] ext(input logic [15:0] p, input bit sg);
    return sg ? {{(W-16){p[15]}}, p} : {{(W-16){1'b0}}, p};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs the queued products back-to-back, then one idle edge; entered at a negedge.
  task automatic run_queue(input bit noise);
    logic [15:0] p0, p1, pp0, pp1;
    bit pc;
    pp0 = '0; pp1 = '0; pc = 0;
    for (int j = 0; j < qx.size(); j++) begin
      p0 = prod(qx[j], qa[j], 0);
      p1 = prod(qx[j], qa[j], 1);
      for (int k = 0; k < L; k++) begin
        start   = (k == 0) || (noise && $urandom_range(0, 3) == 0);
        x       = (k == 0) ? qx[j] : 8'($urandom);
        a_bit   = (k < N) ? qa[j][k] : 1'($urandom);
        clr_acc = (k == 0) ? qc[j] : 1'($urandom);
        @(posedge clk);
        if (k == 0 && j > 0) begin
          macc0 = (pc ? '0 : macc0) + ext(pp0, 0);
          macc1 = (pc ? '0 : macc1) + ext(pp1, 1);
        end
        @(negedge clk);
        chk("p_bit_u", W'(pb0), W'(p0[k]));
        chk("p_bit_s", W'(pb1), W'(p1[k]));
        chk("p_valid", W'({pv0, pv1}), W'(2'b11));
        chk("busy", W'({busy0, busy1}), W'(2'b11));
        chk("done", W'({done0, done1}), (k == L - 1) ? W'(2'b11) : W'(0));
        chk("acc_u", acc0, macc0);
        chk("acc_s", acc1, macc1);
      end
      pp0 = p0; pp1 = p1; pc = qc[j];
    end
    start = 1'b0;
    @(posedge clk);
    macc0 = (pc ? '0 : macc0) + ext(pp0, 0);
    macc1 = (pc ? '0 : macc1) + ext(pp1, 1);
    @(negedge clk);
    chk("idle_outs", W'({busy0, pv0, pb0, done0, busy1, pv1, pb1, done1}), W'(0));
    chk("acc_u_end", acc0, macc0);
    chk("acc_s_end", acc1, macc1);
    qx.delete(); qa.delete(); qc.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_u", {busy0, pv0, pb0, done0, acc0[15:0]}, '0);
    chk("reset_s", {busy1, pv1, pb1, done1, acc1[15:0]}, '0);
    chk("reset_acc", acc0 | acc1, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_full();
    qx.push_back(8'hFF); qa.push_back(8'hFF); qc.push_back(1);
    run_queue(0);
    chk("full_u_const", acc0, 20'h0FE01);
    chk("full_s_const", acc1, 20'h00001);
  endtask

  task automatic test_signed();
    qx.push_back(8'h80); qa.push_back(8'hFF); qc.push_back(1);
    run_queue(0);
    chk("signed_a_const", acc1, 20'h00080);
    qx.push_back(8'h7F); qa.push_back(8'h80); qc.push_back(1);
    run_queue(0);
    chk("signed_b_const", acc1, 20'hFC080);
  endtask

  task automatic test_back_to_back();
    qx.push_back(8'd3); qa.push_back(8'd5); qc.push_back(1);
    qx.push_back(8'd2); qa.push_back(8'd7); qc.push_back(0);
    run_queue(0);
    chk("b2b_u_const", acc0, 20'd29);
    chk("b2b_s_const", acc1, 20'd29);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      qx.push_back(8'hFF); qa.push_back(8'hFF); qc.push_back(i == 0);
    end
    run_queue(0);
    chk("wrap_const", acc0, 20'h0DE11);
  endtask

  task automatic test_ignore_random();
    for (int i = 0; i < 20; i++) begin
      qx.push_back(8'($urandom)); qa.push_back(8'($urandom));
      qc.push_back(i == 0 || $urandom_range(0, 4) == 0);
    end
    run_queue(1);
  endtask

  task automatic test_abort();
    start = 1'b1; x = 8'hA5; a_bit = 1'b1; clr_acc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      start = 1'b0; a_bit = 1'($urandom);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_u", {busy0, pv0, pb0, done0, acc0[15:0]}, '0);
    chk("abort_s", {busy1, pv1, pb1, done1, acc1[15:0]}, '0);
    chk("abort_acc", acc0 | acc1, '0);
    @(negedge clk);
    rst = 1'b0;
    macc0 = '0; macc1 = '0;
    qx.push_back(8'h9C); qa.push_back(8'h3B); qc.push_back(0);
    run_queue(0);
  endtask

  initial begin
    test_reset();
    test_unsigned_full();
    test_signed();
    test_back_to_back();
    test_wrap();
    test_ignore_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
